hazard_scoreboard: RTL and testbench

//  Producer-side companion to operand forwarding: records each destination register written by an

---
 rtl/hazard_scoreboard_pkg.sv | 17 +
 rtl/hazard_scoreboard_sb_entry.sv | 41 ++++
 rtl/hazard_scoreboard.sv | 78 +++++++
 tb/tb_hazard_scoreboard.sv | 123 ++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the ID-stage hazard scoreboard: FwdRisk bit positions,
// register-file geometry and default latencies.
package hazard_scoreboard_pkg;
    localparam int NUM_REGS     = 32;
    localparam int REG_W        = 5;
    localparam int FWD_RS1      = 2;
    localparam int FWD_RS2      = 1;
    localparam int FWD_RD       = 0;
    localparam int LOAD_LAT_DEF = 1;
    localparam int CNT_W_DEF    = 2;

    // x0 is never busy, so a zero index is always a miss.
    function automatic logic reg_busy(input logic [REG_W-1:0] r,
                                      input logic [NUM_REGS-1:0] busy);
        return (r != '0) && busy[r];
    endfunction
endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One tracked architectural register: load countdown plus multi-cycle-pending flag.
module sb_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int LOAD_LAT = LOAD_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic set_load,
    input  logic set_mc,
    input  logic set_alu,
    input  logic clr_mcp,
    output logic pend,
    output logic mcp
);
    logic [CNT_W-1:0] cnt;

    assign pend = (cnt != '0);

    // A new write to this register overrides both the countdown and a same-cycle mc_done clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            mcp <= 1'b0;
        end else if (set_load) begin
            cnt <= CNT_W'(LOAD_LAT);
            mcp <= 1'b0;
        end else if (set_mc) begin
            cnt <= '0;
            mcp <= 1'b1;
        end else begin
            if (set_alu)
                cnt <= '0;
            else if (cnt != '0)
                cnt <= cnt - 1'b1;
            if (clr_mcp)
                mcp <= 1'b0;
        end
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register producer tracking, load-use / multi-cycle
// RAW/WAW / structural stall generation, and a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int LOAD_LAT = LOAD_LAT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_valid,
    input  logic [2:0]       ID_FwdRisk,
    input  logic [REG_W-1:0] ID_rs1,
    input  logic [REG_W-1:0] ID_rs2,
    input  logic [REG_W-1:0] ID_rd,
    input  logic             ID_is_load,
    input  logic             ID_is_mc,
    input  logic             EX_flush,
    input  logic             mc_done,
    input  logic [REG_W-1:0] mc_rd,
    output logic             stall_ID,
    output logic             bubble_EX,
    output logic             mc_busy,
    output logic [WIDTH-1:0] stall_cycles
);
    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] mcp;
    logic raw1, raw2, waw, struc, live, issue, wr_rd;

    assign pend[0] = 1'b0;
    assign mcp[0]  = 1'b0;

    // Hazards look only at registered state; mc_done is not bypassed into this cycle.
    assign raw1  = ID_FwdRisk[FWD_RS1] & reg_busy(ID_rs1, pend | mcp);
    assign raw2  = ID_FwdRisk[FWD_RS2] & reg_busy(ID_rs2, pend | mcp);
    assign waw   = ID_FwdRisk[FWD_RD]  & reg_busy(ID_rd, mcp);
    assign struc = ID_is_mc & mc_busy;

    assign live      = ID_valid & ~EX_flush;
    assign stall_ID  = live & (raw1 | raw2 | waw | struc);
    assign bubble_EX = stall_ID;
    assign issue     = live & ~stall_ID;
    assign wr_rd     = issue & ID_FwdRisk[FWD_RD] & (ID_rd != '0);

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_ent
        logic hit;
        assign hit = wr_rd && (ID_rd == REG_W'(r));

        sb_entry #(.CNT_W(CNT_W), .LOAD_LAT(LOAD_LAT)) u_ent (
            .clk     (clk),
            .rst     (rst),
            .set_load(hit & ID_is_load),
            .set_mc  (hit & ~ID_is_load & ID_is_mc),
            .set_alu (hit & ~ID_is_load & ~ID_is_mc),
            .clr_mcp (mc_done && (mc_rd == REG_W'(r))),
            .pend    (pend[r]),
            .mcp     (mcp[r])
        );
    end

    // A new mc issue wins over a completion in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mc_busy <= 1'b0;
        else if (issue & ID_is_mc)
            mc_busy <= 1'b1;
        else if (mc_done)
            mc_busy <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (stall_ID && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench: driver pushes hand-computed expectations, negedge monitor checks.
module tb_hazard_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic        ID_valid;
    logic [2:0]  ID_FwdRisk;
    logic [4:0]  ID_rs1, ID_rs2, ID_rd;
    logic        ID_is_load, ID_is_mc, EX_flush, mc_done;
    logic [4:0]  mc_rd;
    logic        stall_ID, bubble_EX, mc_busy;
    logic [31:0] stall_cycles;

    typedef struct {
        string       name;
        logic        stall;
        logic        busy;
        logic [31:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.WIDTH(32), .LOAD_LAT(1), .CNT_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .ID_valid    (ID_valid),
        .ID_FwdRisk  (ID_FwdRisk),
        .ID_rs1      (ID_rs1),
        .ID_rs2      (ID_rs2),
        .ID_rd       (ID_rd),
        .ID_is_load  (ID_is_load),
        .ID_is_mc    (ID_is_mc),
        .EX_flush    (EX_flush),
        .mc_done     (mc_done),
        .mc_rd       (mc_rd),
        .stall_ID    (stall_ID),
        .bubble_EX   (bubble_EX),
        .mc_busy     (mc_busy),
        .stall_cycles(stall_cycles)
    );

    task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %0d, expected %0d", nm, what, act, req);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "stall_ID",     32'(stall_ID),  32'(e.stall));
            chk(e.name, "bubble_EX",    32'(bubble_EX), 32'(e.stall));
            chk(e.name, "mc_busy",      32'(mc_busy),   32'(e.busy));
            chk(e.name, "stall_cycles", stall_cycles,   e.sc);
        end
    end

    // One ID cycle: drive inputs just after the edge and queue the expected response.
    task automatic step(input logic r, input logic v, input logic [2:0] f,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                        input logic ld, input logic mc, input logic fl,
                        input logic dn, input logic [4:0] mrd,
                        input logic es, input logic eb, input int esc, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; ID_valid = v; ID_FwdRisk = f; ID_rs1 = s1; ID_rs2 = s2; ID_rd = d;
        ID_is_load = ld; ID_is_mc = mc; EX_flush = fl; mc_done = dn; mc_rd = mrd;
        e.name = nm; e.stall = es; e.busy = eb; e.sc = 32'(esc);
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; ID_valid = 1'b0; ID_FwdRisk = '0; ID_rs1 = '0; ID_rs2 = '0; ID_rd = '0;
        ID_is_load = 1'b0; ID_is_mc = 1'b0; EX_flush = 1'b0; mc_done = 1'b0; mc_rd = '0;

        //   rst v  fwd    rs1 rs2 rd ld mc fl dn mrd  stall busy sc
        step(1, 0, 3'b000, 0,  0,  0, 0, 0, 0, 0, 0,   0, 0, 0, "reset");
        step(0, 1, 3'b001, 0,  0,  5, 1, 0, 0, 0, 0,   0, 0, 0, "lw_x5");
        step(0, 1, 3'b111, 5,  1,  6, 0, 0, 0, 0, 0,   1, 0, 0, "load_use_stall");
        step(0, 1, 3'b111, 5,  1,  6, 0, 0, 0, 0, 0,   0, 0, 1, "load_use_release");
        step(0, 1, 3'b001, 0,  0,  5, 0, 0, 0, 0, 0,   0, 0, 1, "alu_add_x5");
        step(0, 1, 3'b111, 5,  5,  7, 0, 0, 0, 0, 0,   0, 0, 1, "alu_no_stall");
        step(0, 1, 3'b111, 1,  2,  8, 0, 1, 0, 0, 0,   0, 0, 1, "div_x8");
        step(0, 1, 3'b111, 8,  0,  9, 0, 0, 0, 0, 0,   1, 1, 1, "raw_mc_1");
        step(0, 1, 3'b111, 8,  0,  9, 0, 0, 0, 0, 0,   1, 1, 2, "raw_mc_2");
        step(0, 1, 3'b111, 8,  0,  9, 0, 0, 0, 1, 8,   1, 1, 3, "raw_mc_done_no_bypass");
        step(0, 1, 3'b111, 8,  0,  9, 0, 0, 0, 0, 0,   0, 0, 4, "raw_mc_release");
        step(0, 1, 3'b111, 1,  2, 11, 0, 1, 0, 0, 0,   0, 0, 4, "div_x11");
        step(0, 1, 3'b111, 3,  4, 10, 0, 1, 0, 0, 0,   1, 1, 4, "struc_stall");
        step(0, 1, 3'b111, 3,  4, 10, 0, 1, 0, 1, 11,  1, 1, 5, "struc_on_done");
        step(0, 1, 3'b111, 3,  4, 10, 0, 1, 0, 1, 10,  0, 0, 6, "mul_issue_with_done");
        step(0, 1, 3'b111, 10, 0, 12, 0, 0, 0, 0, 0,   1, 1, 6, "busy_kept_raw_x10");
        step(0, 1, 3'b001, 0,  0, 10, 0, 0, 0, 0, 0,   1, 1, 7, "waw_x10");
        step(0, 0, 3'b000, 0,  0,  0, 0, 0, 0, 1, 10,  0, 1, 8, "done_x10");
        step(0, 1, 3'b001, 0,  0,  5, 1, 0, 1, 0, 0,   0, 0, 8, "flushed_lw");
        step(0, 1, 3'b111, 5,  1,  6, 0, 0, 0, 0, 0,   0, 0, 8, "after_flush_no_stall");
        step(0, 1, 3'b001, 0,  0,  0, 1, 0, 0, 0, 0,   0, 0, 8, "lw_x0");
        step(0, 1, 3'b111, 0,  0,  1, 0, 0, 0, 0, 0,   0, 0, 8, "read_x0");
        step(0, 1, 3'b111, 0,  0,  0, 0, 1, 0, 0, 0,   0, 0, 8, "div_x0");
        step(0, 1, 3'b111, 0,  0,  0, 0, 0, 0, 1, 0,   0, 1, 8, "busy_rd0_x0_nostall");
        step(0, 1, 3'b111, 1,  2,  8, 0, 1, 0, 0, 0,   0, 0, 8, "div_x8_again");
        step(0, 1, 3'b111, 8,  0,  9, 0, 0, 0, 0, 0,   1, 1, 8, "raw_before_rst_1");
        step(0, 1, 3'b111, 8,  0,  9, 0, 0, 0, 0, 0,   1, 1, 9, "raw_before_rst_2");
        step(1, 1, 3'b111, 8,  0,  9, 0, 0, 0, 0, 0,   0, 0, 0, "rst_mid_div");
        step(0, 1, 3'b111, 8,  0,  9, 0, 0, 0, 0, 0,   0, 0, 0, "after_rst_no_stall");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
